integer_multiplier_seq: RTL and testbench

// - Sequential shift-and-add multiplier; inverse of the integer divider: rebuilds dividend = quotient*divisor.
// - Used as the check path behind integer_divider, and as a general small-width multiplier.
// - Processes one quotient bit per clock; start/busy/done handshake; result held until next start.

---
 rtl/integer_multiplier_seq.sv | 73 +++++++
 tb/tb_integer_multiplier_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/integer_multiplier_seq.sv
// integer_multiplier_seq: shift-and-add multiplier, one quotient bit per clock; INT_MUL_ADDEND_EN adds remainder.
module integer_multiplier_seq #(
    parameter int M = 5,
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-N:0] quotient,
    input  logic [N-1:0] divisor,
`ifdef INT_MUL_ADDEND_EN
    input  logic [N-1:0] remainder,
`endif
    output logic [M:0]   product,
    output logic         ovf,
    output logic         busy,
    output logic         done
);
    localparam int Q = M - N + 1;
    localparam int CW = $clog2(Q) + 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state;
    logic [M:0]    acc, mc, acc_nxt;
    logic [M-N:0]  mq;
    logic [CW-1:0] cnt;
    logic          last;
    always_comb begin
        acc_nxt = acc + (mq[0] ? mc : '0);
        last    = cnt == CW'(Q - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            product <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mq      <= '0;
            mc      <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    mq    <= quotient;
                    mc    <= {{Q{1'b0}}, divisor};
`ifdef INT_MUL_ADDEND_EN
                    acc   <= {{Q{1'b0}}, remainder};
`else
                    acc   <= '0;
`endif
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
            end else begin
                acc <= acc_nxt;
                mq  <= mq >> 1;
                mc  <= mc << 1;
                cnt <= cnt + 1'b1;
                // final bit folds straight into the published result
                if (last) begin
                    product <= acc_nxt;
                    ovf     <= acc_nxt[M];
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_integer_multiplier_seq.sv
// tb_integer_multiplier_seq: scoreboard bench with an arithmetic reference model; honours INT_MUL_ADDEND_EN.
module tb_integer_multiplier_seq;
    localparam int M = 5;
    localparam int N = 3;
    localparam int Q = M - N + 1;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [Q-1:0] quotient = '0;
    logic [N-1:0] divisor = '0;
    logic [N-1:0] remainder = '0;
    logic [M:0]   product;
    logic         ovf, busy, done;
    int           n_vec = 0, n_bad = 0;
    int           sb[$];
    int           ref_cnt = 0, held = 0;
    bit           exp_done = 1'b0, chk_en = 1'b0;

    integer_multiplier_seq #(.M(M), .N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .quotient(quotient), .divisor(divisor),
`ifdef INT_MUL_ADDEND_EN
        .remainder(remainder),
`endif
        .product(product), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_result(input int q, input int d, input int r);
`ifdef INT_MUL_ADDEND_EN
        return q * d + r;
`else
        return q * d + 0 * r;
`endif
    endfunction

    // reference: an accepted op occupies Q cycles, result published on the last
    always @(posedge clk) begin
        if (rst) begin
            ref_cnt  = 0;
            exp_done = 1'b0;
            held     = 0;
            sb.delete();
        end else begin
            exp_done = (ref_cnt == 1);
            if (ref_cnt != 0) ref_cnt--;
            else if (start) begin
                sb.push_back(ref_result(int'(quotient), int'(divisor), int'(remainder)));
                ref_cnt = Q;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy), int'(ref_cnt != 0));
            chk("done", int'(done), int'(exp_done));
            if (done) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else held = sb.pop_front();
            end
            chk("product", int'(product), held);
            chk("ovf", int'(ovf), int'(held > (2 ** M - 1)));
        end
    end

    task automatic drive(input bit s, input int q, input int d, input int r);
        start     = s;
        quotient  = Q'(q);
        divisor   = N'(d);
        remainder = N'(r);
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int q, input int d, input int r);
        drive(1'b1, q, d, r);
        drive(1'b0, 0, 0, 0);
        repeat (Q) drive(1'b0, 0, 0, 0);
    endtask

    initial begin
        drive(1'b1, 7, 7, 7);
        chk_en = 1'b1;
        drive(1'b1, 7, 7, 7);
        rst = 1'b0;
        drive(1'b0, 0, 0, 0);
        op(6, 4, 0);
        op(7, 7, 0);
        op(5, 0, 0);
        op(0, 7, 0);
        drive(1'b1, 2, 3, 0);
        repeat (4) drive(1'b1, 7, 7, 0);
        repeat (Q + 1) drive(1'b0, 0, 0, 0);
        drive(1'b1, 7, 7, 0);
        drive(1'b0, 0, 0, 0);
        rst = 1'b1;
        drive(1'b0, 0, 0, 0);
        rst = 1'b0;
        repeat (Q + 1) drive(1'b0, 0, 0, 0);
`ifdef INT_MUL_ADDEND_EN
        op(6, 4, 1);
        op(7, 7, 7);
        op(0, 0, 5);
`endif
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        repeat (Q + 2) drive(1'b0, 0, 0, 0);
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
